// File: rtl/arb_req_client.sv
// Requester-side front end for a round-robin arbiter: per-channel FIFOs raise req,
// and the registered one-hot grant pops one channel into a single tagged output register.
module arb_req_client #(
    parameter int N     = 5,
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         in_valid,
    input  logic [N*DW-1:0]      in_data,
    output logic [N-1:0]         in_ready,
    output logic [N-1:0]         req,
    input  logic [N-1:0]         grant,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_id,
    input  logic                 out_ready,
    output logic [7:0]           stale_cnt,
    output logic                 grant_err
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem    [N][DEPTH];
    logic [PW-1:0] rd_ptr [N];
    logic [PW-1:0] wr_ptr [N];
    logic [CW-1:0] count  [N];

    logic          stall;
    logic          multi_hot;
    logic          any_take;
    logic          stale;
    logic [N-1:0]  not_empty;
    logic [N-1:0]  push;
    logic [N-1:0]  take;
    logic [DW-1:0] take_data;
    logic [IW-1:0] take_id;

    assign stall     = out_valid & ~out_ready;
    // x & (x-1) clears the lowest set bit, so anything left means two or more grants.
    assign multi_hot = |(grant & (grant - N'(1)));
    assign any_take  = |take;
    assign stale     = (grant != '0) & ~multi_hot & ~any_take;

    always_comb begin
        // NOTE: every output of this block gets a default before the loop so no
        // path leaves a signal unassigned, which would otherwise infer a latch.
        not_empty = '0;
        in_ready  = '0;
        req       = '0;
        push      = '0;
        take      = '0;
        take_data = '0;
        take_id   = '0;
        for (int i = 0; i < N; i++) begin
            not_empty[i] = (count[i] != '0);
            in_ready[i]  = (count[i] != CW'(DEPTH));
            req[i]       = not_empty[i] & ~stall;
            push[i]      = in_valid[i] & in_ready[i];
            take[i]      = grant[i] & not_empty[i] & ~stall & ~multi_hot;
            if (take[i]) begin
                take_data = mem[i][rd_ptr[i]];
                take_id   = IW'(i);
            end
        end
    end

    // NOTE: storage is not reset; the pointers and counts alone define which
    // entries are valid, so clearing the payload would buy nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
        end
    end

    // NOTE: all state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (take[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(take[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            stale_cnt <= '0;
            grant_err <= 1'b0;
        end else begin
            // A malformed grant freezes the output register entirely.
            if (!multi_hot) begin
                if (any_take) begin
                    out_valid <= 1'b1;
                    out_data  <= take_data;
                    out_id    <= take_id;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
            if (multi_hot) grant_err <= 1'b1;
            if (stale && (stale_cnt != 8'hFF)) stale_cnt <= stale_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_arb_req_client.sv
// Scoreboard bench for arb_req_client: a queue-based channel model predicts every
// output word, and a separate monitor compares each accepted output against it.
module tb_arb_req_client;

    localparam int N     = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int IW    = 3;

    typedef struct packed {
        logic [IW-1:0] ch;
        logic [DW-1:0] data;
    } entry_t;

    logic              clk;
    logic              rstn;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_ready;
    logic [N-1:0]      req;
    logic [N-1:0]      grant;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_id;
    logic              out_ready;
    logic [7:0]        stale_cnt;
    logic              grant_err;

    arb_req_client #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .req(req), .grant(grant),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .stale_cnt(stale_cnt), .grant_err(grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: buffered words in arrival order, expected output words,
    // and the observable flags.
    entry_t              pend[$];
    logic [IW+DW-1:0]    sb[$];
    bit                  m_ov;
    int                  m_stale;
    bit                  m_err;

    // Behavioural round-robin arbiter standing beside the DUT.
    bit                  arb_en;
    int                  rr_last;
    logic [N-1:0]        arb_next;

    // Values sampled in the most recent tick.
    logic [N-1:0]        s_req, s_ready;
    logic                s_valid;
    logic [DW-1:0]       s_data;
    logic [IW-1:0]       s_id;
    logic [7:0]          s_stale;
    logic                s_err;
    int                  tick_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int count_ch(input int ch);
        int c = 0;
        foreach (pend[k]) if (int'(pend[k].ch) == ch) c++;
        return c;
    endfunction

    task automatic pop_ch(input int ch, output logic [DW-1:0] d);
        d = '0;
        for (int k = 0; k < pend.size(); k++) begin
            if (int'(pend[k].ch) == ch) begin
                d = pend[k].data;
                pend.delete(k);
                break;
            end
        end
    endtask

    // One clock cycle: compare against the model, advance the model, drive the arbiter.
    task automatic tick();
        logic [N-1:0]  exp_ready, exp_req, push_en;
        logic [DW-1:0] d;
        bit            stall_m, multi, took;
        int            g, c;
        @(negedge clk);
        tick_no++;
        stall_m = m_ov && !out_ready;
        for (int i = 0; i < N; i++) begin
            exp_ready[i] = (count_ch(i) != DEPTH);
            exp_req[i]   = (count_ch(i) != 0) && !stall_m;
        end
        check("in_ready", in_ready, exp_ready);
        check("req", req, exp_req);
        check("out_valid", out_valid, m_ov);
        check("stale_cnt", stale_cnt, m_stale);
        check("grant_err", grant_err, m_err);
        s_req = req; s_ready = in_ready; s_valid = out_valid;
        s_data = out_data; s_id = out_id; s_stale = stale_cnt; s_err = grant_err;

        push_en = in_valid & exp_ready;
        multi   = $countones(grant) > 1;
        took    = 0;
        if (multi) begin
            m_err = 1;
        end else if (grant != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (grant[i]) g = i;
            if (count_ch(g) != 0 && !stall_m) begin
                pop_ch(g, d);
                sb.push_back({g[IW-1:0], d});
                took = 1;
            end else if (m_stale != 255) begin
                m_stale++;
            end
        end
        if (!multi) begin
            if (took) m_ov = 1;
            else if (m_ov && out_ready) m_ov = 0;
        end
        for (int i = 0; i < N; i++)
            if (push_en[i]) pend.push_back('{ch: i[IW-1:0], data: in_data[i*DW +: DW]});

        arb_next = '0;
        for (int k = 1; k <= N; k++) begin
            c = (rr_last + k) % N;
            if (req[c] && arb_next == '0) arb_next[c] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (arb_en) begin
            grant = arb_next;
            for (int i = 0; i < N; i++) if (arb_next[i]) rr_last = i;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        arb_en    = 1;
        ticks(30);
        check("drain_model_empty", pend.size(), 0);
        check("drain_sb_empty", sb.size(), 0);
        arb_en = 0;
        grant  = '0;
        tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_stale_cnt", stale_cnt, 0);
        check("rst_grant_err", grant_err, 0);
        check("rst_in_ready", in_ready, 5'b11111);
        check("rst_req", req, 5'b00000);
    endtask

    task automatic model_reset();
        pend.delete();
        sb.delete();
        m_ov = 0; m_stale = 0; m_err = 0;
        rr_last = N - 1;
        arb_en = 0;
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] d);
        in_data[ch*DW +: DW] = d;
    endtask

    // Monitor: every accepted output word must be the oldest predicted one.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_word: got 0x%0h, expected none pending (t=%0t)",
                             {out_id, out_data}, $time);
                end else begin
                    check("out_word", {out_id, out_data}, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ids[$];
        int            at[$];
        int            st_before;
        logic [DW-1:0] w;
        int            g;

        rstn = 1'b0; in_valid = '0; in_data = '0; grant = '0; out_ready = 1'b1;
        model_reset();
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single word on channel 2 with the arbiter running.
        arb_en = 1;
        in_valid = 5'b00100; set_data(2, 8'hA5);
        tick();
        in_valid = '0;
        tick();
        check("t1_req", s_req, 5'b00100);
        tick();
        check("t1_not_yet_valid", s_valid, 0);
        tick();
        check("t1_out_valid", s_valid, 1);
        check("t1_out_data", s_data, 8'hA5);
        check("t1_out_id", s_id, 2);
        check("t1_stale", s_stale, 0);
        drain();

        // Fairness: two words per channel, then let the arbiter loose.
        for (int k = 0; k < 2; k++) begin
            in_valid = 5'b11111;
            for (int i = 0; i < N; i++) set_data(i, 8'($urandom));
            tick();
        end
        in_valid = '0;
        st_before = m_stale;
        rr_last = N - 1;
        arb_en = 1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (s_valid) begin
                ids.push_back(int'(s_id));
                at.push_back(tick_no);
                if (ids.size() == 10) check("t2_no_stale_before_drain", s_stale, st_before);
            end
        end
        check("t2_count", ids.size(), 10);
        for (int k = 0; k < 10 && k < ids.size(); k++) begin
            check("t2_id_seq", ids[k], k % N);
            if (k > 0) check("t2_back_to_back", at[k] - at[k-1], 1);
        end
        drain();

        // Backpressure: hold one word out and offer a grant during the stall.
        in_valid = 5'b01010; set_data(1, 8'h3C); set_data(3, 8'hC3);
        tick();
        in_valid = '0; out_ready = 1'b0; grant = 5'b00010;
        tick();
        grant = '0;
        tick();
        check("t3_req_stalled", s_req, 5'b00000);
        check("t3_valid_held", s_valid, 1);
        st_before = s_stale;
        grant = 5'b01000;
        tick();
        grant = '0;
        tick();
        check("t3_stale_inc", s_stale, st_before + 1);
        check("t3_data_stable", s_data, 8'h3C);
        out_ready = 1'b1;
        tick();
        drain();

        // Full FIFO on channel 0, then pop+push in one cycle.
        in_valid = 5'b00001; set_data(0, 8'h11);
        tick();
        set_data(0, 8'h22);
        tick();
        set_data(0, 8'h33);
        tick();
        check("t4_full_not_ready", s_ready[0], 0);
        grant = 5'b00001;
        tick();
        check("t4_full_during_pop", s_ready[0], 0);
        tick();
        check("t4_ready_after_pop", s_ready[0], 1);
        grant = '0; in_valid = '0;
        tick();
        check("t4_count_kept", s_ready[0], 1);
        drain();

        // Multi-hot grant with channels 0 and 1 holding data.
        in_valid = 5'b00011; set_data(0, 8'h5A); set_data(1, 8'h6B);
        tick();
        in_valid = '0;
        st_before = m_stale;
        grant = 5'b00011;
        tick();
        grant = '0;
        tick();
        check("t5_grant_err", s_err, 1);
        check("t5_out_valid_unchanged", s_valid, 0);
        check("t5_stale_unchanged", s_stale, st_before);
        tick();
        check("t5_grant_err_sticky", s_err, 1);
        drain();

        // Random traffic with the behavioural arbiter.
        arb_en = 1;
        for (int k = 0; k < 300; k++) begin
            in_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_data(i, 8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Random one-hot or idle grants, many of them stale.
        for (int k = 0; k < 300; k++) begin
            in_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_data(i, 8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            g = $urandom_range(0, N + 1);
            grant = (g < N) ? N'(1) << g : '0;
            tick();
        end
        drain();

        // Reset while a word is held and FIFOs are occupied.
        in_valid = 5'b11111;
        for (int i = 0; i < N; i++) set_data(i, 8'($urandom));
        out_ready = 1'b0;
        tick();
        in_valid = '0; grant = 5'b00100;
        tick();
        grant = '0;
        tick();
        check("t6_valid_before_reset", s_valid, 1);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        grant = '0; out_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        arb_en = 1;
        for (int k = 0; k < 60; k++) begin
            in_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_data(i, 8'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
